rotated_sprite_mapper: RTL and testbench
========================================

ROTATED_SPRITE_MAPPER -- requirements
Module: rotated_sprite_mapper

Interface
REQ-001 SHALL have parameter P_IMG_W, default 80, sprite image width in pixels.
REQ-002 SHALL have parameter P_IMG_H, default 480, sprite image height in pixels.
REQ-003 SHALL have parameter P_NUM_SPR, default 2, number of independently placed sprites (1-8).
REQ-004 SHALL have parameter P_ADDR_W, default 16, ROM address width.
REQ-005 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port pix_valid  input  1  VGA_X/VGA_Y qualify this cycle.
REQ-008 SHALL have port VGA_X, VGA_Y  input  11 each  unsigned screen coordinate.
REQ-009 SHALL have port frame_start  input  1  one-cycle pulse, commits shadow config.
REQ-010 SHALL have port cfg_wr  input  1  write shadow config entry cfg_idx.
REQ-011 SHALL have port cfg_idx  input  3  sprite index; writes with cfg_idx >= P_NUM_SPR ignored.
REQ-012 SHALL have port cfg_en, cfg_mirror  input  1 each  sprite enable, horizontal mirror.
REQ-013 SHALL have port cfg_ox, cfg_oy  input  11 each  unsigned sprite origin.
REQ-014 SHALL have port cfg_cos, cfg_sin  input  10 each  signed Q1.8 cos/sin of inverse angle.
REQ-015 SHALL have port cfg_pending  output  1  shadow differs from active (written since last commit).
REQ-016 SHALL have port out_valid  output  1  result for pixel presented 4 cycles earlier.
REQ-017 SHALL have port hit  output  1  pixel lies inside an enabled sprite.
REQ-018 SHALL have port sprite_id  output  3  index of winning sprite.
REQ-019 SHALL have port rom_addr  output  P_ADDR_W  image ROM address.

Function
REQ-020 SHALL hold per-sprite shadow and active config register banks; cfg_wr updates shadow only.
REQ-021 SHALL copy all shadow entries to active on frame_start and clear cfg_pending; cfg_wr same cycle as frame_start: active gets pre-write shadow, write lands in shadow, cfg_pending=1.
REQ-022 SHALL use only active config in the datapath; mid-frame cfg_wr never alters output.
REQ-023 SHALL pipeline in 4 registered stages, no backpressure: S1 dx=X-ox, dy=Y-oy (signed 12b); S2 four products c*dx, s*dy, s*dx, c*dy (22b); S3 u=(c*dx-s*dy)>>>8, v=(s*dx+c*dy)>>>8 (arithmetic floor), per-sprite in-bounds 0<=u<P_IMG_W and 0<=v<P_IMG_H and en; S4 select and address.
REQ-024 SHALL assert out_valid exactly 4 cycles after pix_valid, one-for-one; gaps in pix_valid propagate as gaps.
REQ-025 SHALL select lowest-index hitting sprite on overlap; hit=0 gives sprite_id=0, rom_addr=0.
REQ-026 SHALL compute rom_addr = u + P_IMG_W*v of winning sprite, truncated to P_ADDR_W.
REQ-027 SHALL hold hit/sprite_id/rom_addr at 0 when out_valid=0.

Reset
REQ-028 SHALL on reset assertion immediately clear out_valid, hit, sprite_id, rom_addr, cfg_pending and all pipeline valids.
REQ-029 SHALL reset both banks to en=0, mirror=0, ox=oy=0, cos=256, sin=0.
REQ-030 SHALL discard in-flight pixels on reset mid-frame; first out_valid is 4 cycles after first post-reset pix_valid.

Configuration
REQ-031 SHALL, with SPRITE_MIRROR_EN defined, replace u by P_IMG_W-1-u after the bounds check for sprites with active mirror=1.
REQ-032 SHALL, without SPRITE_MIRROR_EN, ignore cfg_mirror and store no mirror bits.

Verification
REQ-033 Sprite0 en, o=(300,200), cos=256, sin=0, frame_start; pixel (305,210) -> 4 cycles later out_valid=1, hit=1, id=0, rom_addr=805.
REQ-034 Same config, pixel (299,200) -> hit=0, rom_addr=0; pixel (380,200) -> hit=0 (u=80).
REQ-035 Sprite0 cos=0, sin=-256, o=(300,200); pixel (296,203) -> u=3, v=4, rom_addr=323.
REQ-036 Sprites 0 and 1 identical, both en; pixel inside -> id=0; disable sprite0 via cfg_wr+frame_start -> id=1.
REQ-037 cfg_wr moving sprite0 mid-frame -> outputs unchanged, cfg_pending=1 until frame_start, then new origin applies; cfg_wr coincident with frame_start -> cfg_pending stays 1.
REQ-038 SPRITE_MIRROR_EN, mirror=1, theta 0 case of REQ-033 -> rom_addr=74+800=874; reset asserted mid-stream -> out_valid=0 immediately.

Source files
------------

// File: rtl/rotated_sprite_mapper.sv
// -----------------------------------------------------------------------------
// rotated_sprite_mapper
//
// Maps each incoming VGA pixel coordinate into the image space of up to
// P_NUM_SPR independently placed and rotated sprites. For every sprite the
// pixel offset from the sprite origin is rotated by the inverse angle
// (cos/sin given in signed Q1.8) to give image coordinates (u, v). If any
// enabled sprite contains the pixel, the lowest-index one wins and the image
// ROM address u + P_IMG_W*v is produced.
//
// Sprite configuration is double-buffered. cfg_wr only touches the shadow
// bank. frame_start copies the whole shadow bank into the active bank, which
// is the only bank the datapath reads, so a frame never sees a half-applied
// update.
//
// Optional feature macro: SPRITE_MIRROR_EN
//   When defined, sprites with mirror=1 are flipped horizontally
//   (u -> P_IMG_W-1-u) after the bounds check. When undefined, cfg_mirror is
//   ignored and no mirror state is stored.
//
// Ports
//   clk          single clock, all logic on the rising edge
//   reset        asynchronous active-low reset
//   pix_valid    VGA_X/VGA_Y are meaningful this cycle
//   VGA_X/VGA_Y  unsigned 11-bit screen coordinate
//   frame_start  one-cycle pulse that commits shadow config to active
//   cfg_wr       write shadow entry cfg_idx (ignored if cfg_idx >= P_NUM_SPR)
//   cfg_en, cfg_mirror, cfg_ox, cfg_oy, cfg_cos, cfg_sin  shadow entry data
//   cfg_pending  shadow has been written since the last commit
//   out_valid    result for the pixel presented 4 cycles earlier
//   hit          pixel lies inside an enabled sprite
//   sprite_id    index of the winning sprite (0 when no hit)
//   rom_addr     image ROM address of the winning sprite (0 when no hit)
// -----------------------------------------------------------------------------
module rotated_sprite_mapper #(
    parameter int P_IMG_W   = 80,
    parameter int P_IMG_H   = 480,
    parameter int P_NUM_SPR = 2,
    parameter int P_ADDR_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pix_valid,
    input  logic [10:0]         VGA_X,
    input  logic [10:0]         VGA_Y,
    input  logic                frame_start,
    input  logic                cfg_wr,
    input  logic [2:0]          cfg_idx,
    input  logic                cfg_en,
    input  logic                cfg_mirror,
    input  logic [10:0]         cfg_ox,
    input  logic [10:0]         cfg_oy,
    input  logic [9:0]          cfg_cos,
    input  logic [9:0]          cfg_sin,
    output logic                cfg_pending,
    output logic                out_valid,
    output logic                hit,
    output logic [2:0]          sprite_id,
    output logic [P_ADDR_W-1:0] rom_addr
);

    // Configuration banks
    logic               shadowEn_q  [P_NUM_SPR];
    logic [10:0]        shadowOx_q  [P_NUM_SPR];
    logic [10:0]        shadowOy_q  [P_NUM_SPR];
    logic signed [9:0]  shadowCos_q [P_NUM_SPR];
    logic signed [9:0]  shadowSin_q [P_NUM_SPR];
    logic               activeEn_q  [P_NUM_SPR];
    logic [10:0]        activeOx_q  [P_NUM_SPR];
    logic [10:0]        activeOy_q  [P_NUM_SPR];
    logic signed [9:0]  activeCos_q [P_NUM_SPR];
    logic signed [9:0]  activeSin_q [P_NUM_SPR];
`ifdef SPRITE_MIRROR_EN
    logic               shadowMirror_q [P_NUM_SPR];
    logic               activeMirror_q [P_NUM_SPR];
`else
    logic               unusedMirror;
    assign unusedMirror = cfg_mirror;
`endif
    logic               cfgPending_q;
    logic               cfgAccept;

    // Pipeline registers
    logic               s1Valid_q;
    logic signed [11:0] s1Dx_q     [P_NUM_SPR];
    logic signed [11:0] s1Dy_q     [P_NUM_SPR];
    logic               s2Valid_q;
    logic signed [21:0] s2CosDx_q  [P_NUM_SPR];
    logic signed [21:0] s2SinDy_q  [P_NUM_SPR];
    logic signed [21:0] s2SinDx_q  [P_NUM_SPR];
    logic signed [21:0] s2CosDy_q  [P_NUM_SPR];
    logic               s3Valid_q;
    logic               s3Hit_q    [P_NUM_SPR];
    logic [14:0]        s3U_q      [P_NUM_SPR];
    logic [14:0]        s3V_q      [P_NUM_SPR];
    logic               outValid_q;
    logic               hit_q;
    logic [2:0]         spriteId_q;
    logic [P_ADDR_W-1:0] romAddr_q;

    // Stage-3 / stage-4 next-state values
    logic signed [22:0] uFull      [P_NUM_SPR];
    logic signed [22:0] vFull      [P_NUM_SPR];
    logic [14:0]        uRaw       [P_NUM_SPR];
    logic [14:0]        vRaw       [P_NUM_SPR];
    logic               s3Hit_d    [P_NUM_SPR];
    logic [14:0]        s3U_d      [P_NUM_SPR];
    logic [14:0]        s3V_d      [P_NUM_SPR];
    logic               winFound_d;
    logic [2:0]         winId_d;
    logic [31:0]        winAddr_d;

    // A write addressed past the last sprite touches nothing, so it must not
    // flag the shadow bank as dirty either.
    assign cfgAccept = cfg_wr && (32'(cfg_idx) < 32'(P_NUM_SPR));

    // Shadow bank: only cfg_wr changes it. Reset value is an enabled-off,
    // unrotated sprite at the origin (cos = 1.0, sin = 0).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < P_NUM_SPR; i++) begin
                shadowEn_q[i]  <= 1'b0;
                shadowOx_q[i]  <= '0;
                shadowOy_q[i]  <= '0;
                shadowCos_q[i] <= 10'sd256;
                shadowSin_q[i] <= '0;
`ifdef SPRITE_MIRROR_EN
                shadowMirror_q[i] <= 1'b0;
`endif
            end
        end else if (cfg_wr) begin
            for (int i = 0; i < P_NUM_SPR; i++) begin
                if (cfg_idx == 3'(i)) begin
                    shadowEn_q[i]  <= cfg_en;
                    shadowOx_q[i]  <= cfg_ox;
                    shadowOy_q[i]  <= cfg_oy;
                    shadowCos_q[i] <= cfg_cos;
                    shadowSin_q[i] <= cfg_sin;
`ifdef SPRITE_MIRROR_EN
                    shadowMirror_q[i] <= cfg_mirror;
`endif
                end
            end
        end
    end

    // Active bank: bulk copy on frame_start. A write in the same cycle still
    // lands in the shadow, so the active bank takes the pre-write contents.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < P_NUM_SPR; i++) begin
                activeEn_q[i]  <= 1'b0;
                activeOx_q[i]  <= '0;
                activeOy_q[i]  <= '0;
                activeCos_q[i] <= 10'sd256;
                activeSin_q[i] <= '0;
`ifdef SPRITE_MIRROR_EN
                activeMirror_q[i] <= 1'b0;
`endif
            end
        end else if (frame_start) begin
            for (int i = 0; i < P_NUM_SPR; i++) begin
                activeEn_q[i]  <= shadowEn_q[i];
                activeOx_q[i]  <= shadowOx_q[i];
                activeOy_q[i]  <= shadowOy_q[i];
                activeCos_q[i] <= shadowCos_q[i];
                activeSin_q[i] <= shadowSin_q[i];
`ifdef SPRITE_MIRROR_EN
                activeMirror_q[i] <= shadowMirror_q[i];
`endif
            end
        end
    end

    // Pending flag: a write wins over a coincident commit because that write
    // did not make it into the active bank.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfgPending_q <= 1'b0;
        end else if (cfgAccept) begin
            cfgPending_q <= 1'b1;
        end else if (frame_start) begin
            cfgPending_q <= 1'b0;
        end
    end

    // Stage 3 combinational part: rotate, floor-shift out the Q1.8 fraction,
    // bounds check, then optionally mirror the in-bounds u.
    always_comb begin
        for (int i = 0; i < P_NUM_SPR; i++) begin
            uFull[i]   = 23'(s2CosDx_q[i]) - 23'(s2SinDy_q[i]);
            vFull[i]   = 23'(s2SinDx_q[i]) + 23'(s2CosDy_q[i]);
            uRaw[i]    = 15'(uFull[i] >>> 8);
            vRaw[i]    = 15'(vFull[i] >>> 8);
            s3Hit_d[i] = activeEn_q[i]
                         && !uRaw[i][14] && (32'(uRaw[i]) < 32'(P_IMG_W))
                         && !vRaw[i][14] && (32'(vRaw[i]) < 32'(P_IMG_H));
            s3U_d[i]   = uRaw[i];
            s3V_d[i]   = vRaw[i];
`ifdef SPRITE_MIRROR_EN
            if (activeMirror_q[i]) begin
                s3U_d[i] = 15'(P_IMG_W - 1) - uRaw[i];
            end
`endif
        end
    end

    // Stage 4 combinational part: scanning from the top index down lets the
    // lowest hitting index overwrite everything else.
    always_comb begin
        winFound_d = 1'b0;
        winId_d    = '0;
        winAddr_d  = '0;
        for (int i = P_NUM_SPR - 1; i >= 0; i--) begin
            if (s3Hit_q[i]) begin
                winFound_d = 1'b1;
                winId_d    = 3'(i);
                winAddr_d  = 32'(s3U_q[i]) + 32'(P_IMG_W) * 32'(s3V_q[i]);
            end
        end
    end

    // Four-stage pipeline with no stall; each valid bit simply follows the
    // previous stage so gaps in pix_valid travel through unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1Valid_q  <= 1'b0;
            s2Valid_q  <= 1'b0;
            s3Valid_q  <= 1'b0;
            outValid_q <= 1'b0;
            hit_q      <= 1'b0;
            spriteId_q <= '0;
            romAddr_q  <= '0;
            for (int i = 0; i < P_NUM_SPR; i++) begin
                s1Dx_q[i]    <= '0;
                s1Dy_q[i]    <= '0;
                s2CosDx_q[i] <= '0;
                s2SinDy_q[i] <= '0;
                s2SinDx_q[i] <= '0;
                s2CosDy_q[i] <= '0;
                s3Hit_q[i]   <= 1'b0;
                s3U_q[i]     <= '0;
                s3V_q[i]     <= '0;
            end
        end else begin
            s1Valid_q  <= pix_valid;
            s2Valid_q  <= s1Valid_q;
            s3Valid_q  <= s2Valid_q;
            outValid_q <= s3Valid_q;
            hit_q      <= s3Valid_q && winFound_d;
            spriteId_q <= (s3Valid_q && winFound_d) ? winId_d : 3'd0;
            romAddr_q  <= (s3Valid_q && winFound_d) ? P_ADDR_W'(winAddr_d) : '0;
            for (int i = 0; i < P_NUM_SPR; i++) begin
                s1Dx_q[i]    <= $signed({1'b0, VGA_X}) - $signed({1'b0, activeOx_q[i]});
                s1Dy_q[i]    <= $signed({1'b0, VGA_Y}) - $signed({1'b0, activeOy_q[i]});
                s2CosDx_q[i] <= 22'(activeCos_q[i]) * 22'(s1Dx_q[i]);
                s2SinDy_q[i] <= 22'(activeSin_q[i]) * 22'(s1Dy_q[i]);
                s2SinDx_q[i] <= 22'(activeSin_q[i]) * 22'(s1Dx_q[i]);
                s2CosDy_q[i] <= 22'(activeCos_q[i]) * 22'(s1Dy_q[i]);
                s3Hit_q[i]   <= s3Hit_d[i];
                s3U_q[i]     <= s3U_d[i];
                s3V_q[i]     <= s3V_d[i];
            end
        end
    end

    assign cfg_pending = cfgPending_q;
    assign out_valid   = outValid_q;
    assign hit         = hit_q;
    assign sprite_id   = spriteId_q;
    assign rom_addr    = romAddr_q;

endmodule

// File: tb/tb_rotated_sprite_mapper.sv
// -----------------------------------------------------------------------------
// tb_rotated_sprite_mapper
//
// Directed bench for rotated_sprite_mapper with default parameters
// (80x480 image, 2 sprites, 16-bit ROM address). Expected results are
// hand-computed from the sprite geometry.
// -----------------------------------------------------------------------------
module tb_rotated_sprite_mapper;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_valid;
    logic [10:0] VGA_X, VGA_Y;
    logic        frame_start;
    logic        cfg_wr;
    logic [2:0]  cfg_idx;
    logic        cfg_en, cfg_mirror;
    logic [10:0] cfg_ox, cfg_oy;
    logic [9:0]  cfg_cos, cfg_sin;
    logic        cfg_pending;
    logic        out_valid;
    logic        hit;
    logic [2:0]  sprite_id;
    logic [15:0] rom_addr;

    int checkCount = 0;
    int passCount  = 0;

    rotated_sprite_mapper dut (
        .clk         (clk),
        .reset       (reset),
        .pix_valid   (pix_valid),
        .VGA_X       (VGA_X),
        .VGA_Y       (VGA_Y),
        .frame_start (frame_start),
        .cfg_wr      (cfg_wr),
        .cfg_idx     (cfg_idx),
        .cfg_en      (cfg_en),
        .cfg_mirror  (cfg_mirror),
        .cfg_ox      (cfg_ox),
        .cfg_oy      (cfg_oy),
        .cfg_cos     (cfg_cos),
        .cfg_sin     (cfg_sin),
        .cfg_pending (cfg_pending),
        .out_valid   (out_valid),
        .hit         (hit),
        .sprite_id   (sprite_id),
        .rom_addr    (rom_addr)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Write one shadow entry, optionally together with a frame_start pulse
    task automatic writeCfg(input int idx, input int en, input int mir,
                            input int ox, input int oy, input int c, input int s,
                            input int withFrame);
        @(negedge clk);
        cfg_wr      = 1'b1;
        cfg_idx     = 3'(idx);
        cfg_en      = 1'(en);
        cfg_mirror  = 1'(mir);
        cfg_ox      = 11'(ox);
        cfg_oy      = 11'(oy);
        cfg_cos     = 10'(c);
        cfg_sin     = 10'(s);
        frame_start = 1'(withFrame);
        @(negedge clk);
        cfg_wr      = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic commitFrame();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    // Present one pixel for a single cycle; returns just after the sampling edge
    task automatic applyStimulus(input int x, input int y);
        @(negedge clk);
        pix_valid = 1'b1;
        VGA_X     = 11'(x);
        VGA_Y     = 11'(y);
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    // Send a pixel and check the result appears exactly 4 cycles later, once
    task automatic runPixel(input string tag, input int x, input int y,
                            input int expHit, input int expId, input int expAddr);
        applyStimulus(x, y);
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput({tag, "_early"}, 32'(out_valid), 0);
        @(posedge clk);
        #1;
        checkOutput({tag, "_valid"}, 32'(out_valid), 1);
        checkOutput({tag, "_hit"},   32'(hit),       32'(expHit));
        checkOutput({tag, "_id"},    32'(sprite_id), 32'(expId));
        checkOutput({tag, "_addr"},  32'(rom_addr),  32'(expAddr));
        @(posedge clk);
        #1;
        checkOutput({tag, "_once"}, 32'(out_valid), 0);
    endtask

    initial begin
        int seen;
        reset       = 1'b0;
        pix_valid   = 1'b0;
        VGA_X       = '0;
        VGA_Y       = '0;
        frame_start = 1'b0;
        cfg_wr      = 1'b0;
        cfg_idx     = '0;
        cfg_en      = 1'b0;
        cfg_mirror  = 1'b0;
        cfg_ox      = '0;
        cfg_oy      = '0;
        cfg_cos     = '0;
        cfg_sin     = '0;

        // Reset state
        #12;
        checkOutput("rst_valid",   32'(out_valid),   0);
        checkOutput("rst_hit",     32'(hit),         0);
        checkOutput("rst_id",      32'(sprite_id),   0);
        checkOutput("rst_addr",    32'(rom_addr),    0);
        checkOutput("rst_pending", 32'(cfg_pending), 0);
        @(negedge clk);
        reset = 1'b1;

        // Shadow write alone must not reach the datapath
        writeCfg(0, 1, 0, 300, 200, 256, 0, 0);
        checkOutput("pend_after_wr", 32'(cfg_pending), 1);
        runPixel("uncommitted", 305, 210, 0, 0, 0);
        commitFrame();
        checkOutput("pend_after_fs", 32'(cfg_pending), 0);

        // Unrotated sprite at (300,200): interior and edges
        runPixel("basic",     305, 210, 1, 0, 805);
        runPixel("left_out",  299, 200, 0, 0, 0);
        runPixel("right_out", 380, 200, 0, 0, 0);
        runPixel("right_in",  379, 200, 1, 0, 79);
        runPixel("top_out",   300, 199, 0, 0, 0);
        runPixel("bot_in",    300, 679, 1, 0, 38320);
        runPixel("bot_out",   300, 680, 0, 0, 0);

        // Mirror bit: flips u only when the feature is built in
        writeCfg(0, 1, 1, 300, 200, 256, 0, 0);
        commitFrame();
`ifdef SPRITE_MIRROR_EN
        runPixel("mirror", 305, 210, 1, 0, 874);
`else
        runPixel("mirror_ignored", 305, 210, 1, 0, 805);
`endif

        // 90-degree rotation: cos=0, sin=-1.0 -> u=3, v=4
        writeCfg(0, 1, 0, 300, 200, 0, -256, 0);
        commitFrame();
        runPixel("rot90", 296, 203, 1, 0, 323);

        // Overlapping sprites: lowest index wins, then sprite 1 after disabling 0
        writeCfg(0, 1, 0, 300, 200, 256, 0, 0);
        writeCfg(1, 1, 0, 300, 200, 256, 0, 0);
        commitFrame();
        runPixel("overlap_0", 305, 210, 1, 0, 805);
        writeCfg(0, 0, 0, 300, 200, 256, 0, 0);
        commitFrame();
        runPixel("overlap_1", 305, 210, 1, 1, 805);

        // Out-of-range index is ignored entirely
        writeCfg(5, 1, 0, 0, 0, 256, 0, 0);
        checkOutput("idx_ignored_pend", 32'(cfg_pending), 0);
        runPixel("idx_ignored", 305, 210, 1, 1, 805);

        // Mid-frame move of sprite 0 takes effect only after commit
        writeCfg(1, 0, 0, 0, 0, 256, 0, 0);
        writeCfg(0, 1, 0, 300, 200, 256, 0, 0);
        commitFrame();
        writeCfg(0, 1, 0, 310, 200, 256, 0, 0);
        checkOutput("midframe_pend", 32'(cfg_pending), 1);
        runPixel("midframe_old", 305, 210, 1, 0, 805);
        checkOutput("midframe_pend2", 32'(cfg_pending), 1);
        commitFrame();
        checkOutput("commit_pend", 32'(cfg_pending), 0);
        runPixel("moved_new", 315, 210, 1, 0, 805);
        runPixel("moved_old", 305, 210, 0, 0, 0);

        // Write coincident with frame_start: commit takes pre-write shadow
        writeCfg(0, 1, 0, 320, 200, 256, 0, 1);
        checkOutput("coinc_pend", 32'(cfg_pending), 1);
        runPixel("coinc_old", 315, 210, 1, 0, 805);
        commitFrame();
        checkOutput("coinc_commit_pend", 32'(cfg_pending), 0);
        runPixel("coinc_new", 325, 210, 1, 0, 805);

        // Gap in pix_valid propagates as a gap in out_valid
        @(negedge clk);
        pix_valid = 1'b1; VGA_X = 11'd325; VGA_Y = 11'd210;
        @(negedge clk);
        pix_valid = 1'b0;
        @(negedge clk);
        pix_valid = 1'b1; VGA_X = 11'd320; VGA_Y = 11'd200;
        @(negedge clk);
        pix_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("gap_a_valid", 32'(out_valid), 1);
        checkOutput("gap_a_addr",  32'(rom_addr),  805);
        @(posedge clk);
        #1;
        checkOutput("gap_hole_valid", 32'(out_valid), 0);
        checkOutput("gap_hole_hit",   32'(hit),       0);
        @(posedge clk);
        #1;
        checkOutput("gap_b_valid", 32'(out_valid), 1);
        checkOutput("gap_b_hit",   32'(hit),       1);
        checkOutput("gap_b_addr",  32'(rom_addr),  0);

        // Reset mid-stream: outputs clear at once and in-flight pixels vanish
        writeCfg(1, 1, 0, 0, 0, 256, 0, 0);
        @(negedge clk);
        pix_valid = 1'b1; VGA_X = 11'd325; VGA_Y = 11'd210;
        @(negedge clk);
        VGA_X = 11'd326;
        @(negedge clk);
        pix_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("pre_rst_valid", 32'(out_valid), 1);
        checkOutput("pre_rst_addr",  32'(rom_addr),  805);
        reset = 1'b0;
        #1;
        checkOutput("async_rst_valid",   32'(out_valid),   0);
        checkOutput("async_rst_hit",     32'(hit),         0);
        checkOutput("async_rst_addr",    32'(rom_addr),    0);
        checkOutput("async_rst_pending", 32'(cfg_pending), 0);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        checkOutput("discarded", 32'(seen), 0);

        // Banks were reset to disabled: first post-reset pixel misses on time
        runPixel("post_rst", 325, 210, 0, 0, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
